// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one 32-bit column per clock, four compute cycles per block.
// Define INV_MIX_EN to add the inv port and the InvMixColumns datapath.
`timescale 1ns/1ps
module mix_columns_iter #(
    parameter int COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
`ifdef INV_MIX_EN
    ,
    input  logic         inv
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and out_data stays stable while out_valid is high and unaccepted.

    localparam logic [1:0] LAST_COL = 2'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [0:127] data_q, data_d;
    logic         bypass_q, bypass_d;
`ifdef INV_MIX_EN
    logic         inv_q, inv_d;
`endif

    logic [0:31]  col_in;
    logic [0:31]  col_out;
    logic [7:0]   a  [4];
    logic [7:0]   x2 [4];
    logic [7:0]   fwd [4];
`ifdef INV_MIX_EN
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   ivr [4];
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Single shared column datapath; the column counter selects which slice it sees.
    always_comb begin : col_mix
        col_in = data_q[32*int'(col_q) +: 32];
        for (int k = 0; k < 4; k++) begin
            a[k]  = col_in[8*k +: 8];
            x2[k] = xtime(a[k]);
        end
        fwd[0] = x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3];
        fwd[1] = a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3];
        fwd[2] = a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3];
        fwd[3] = x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3];
        col_out = {fwd[0], fwd[1], fwd[2], fwd[3]};
`ifdef INV_MIX_EN
        // 09/0b/0d/0e multiples assembled from the 2x/4x/8x xtime chain.
        for (int k = 0; k < 4; k++) begin
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        ivr[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        ivr[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        ivr[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        ivr[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        if (inv_q) begin
            col_out = {ivr[0], ivr[1], ivr[2], ivr[3]};
        end
`endif
    end

    always_comb begin : fsm_next
        state_d  = state_q;
        col_d    = col_q;
        data_d   = data_q;
        bypass_d = bypass_q;
`ifdef INV_MIX_EN
        inv_d    = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    bypass_d = in_bypass;
`ifdef INV_MIX_EN
                    inv_d    = inv;
`endif
                    col_d    = 2'd0;
                    state_d  = in_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!bypass_q) begin
                    data_d[32*int'(col_q) +: 32] = col_out;
                end
                col_d = col_q + 2'd1;
                if (col_q == LAST_COL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= 2'd0;
            data_q   <= '0;
            bypass_q <= 1'b0;
`ifdef INV_MIX_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            data_q   <= data_d;
            bypass_q <= bypass_d;
`ifdef INV_MIX_EN
            inv_q    <= inv_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

    hold_a: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(out_data));
    excl_a: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative AES MixColumns stage; sits directly downstream of the combinational ShiftRows stage and consumes its 128-bit output.
- Processes one 32-bit column per clock, 4 compute cycles per block.
- Uses a valid/ready handshake on both sides and a bypass for the final AES round, which has no MixColumns.

Parameters:
- COLS, 4, number of columns per state; fixed at 4 for AES; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  block can accept a state
- in_data  input  [0:127]  ShiftRows output state
- in_bypass  input  1  final round; pass state through unmodified
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  [0:127]  MixColumns result
- inv  input  1  inverse MixColumns select; present only with INV_MIX_EN

Behaviour:
- Byte layout:
  - byte k = bits [8k:8k+7]; bit 8k is the byte MSB.
  - column c = bytes 4c..4c+3; byte 4c is row 0.
  - Same column-major layout as the ShiftRows stage.
- Column transform, forward:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - 2x = xtime(x) = (x<<1) ^ (MSB ? 8'h1b : 0); 3x = xtime(x)^x; all arithmetic in GF(2^8).
- Single-ported column datapath, one instance, muxed by a column counter.
- States: IDLE, BUSY, DONE.
- Reset (async, immediate):
  - state = IDLE, column counter = 0, data register = 0, captured bypass/inv = 0.
  - in_ready = 1, out_valid = 0, out_data = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_data, in_bypass (and inv) into registers.
  - Go to DONE if in_bypass = 1, else go to BUSY with column counter = 0.
- BUSY:
  - in_ready = 0.
  - Each cycle, replace column[counter] in the data register with its transform, then increment the counter.
  - After column 3 is written, go to DONE; the counter wraps to 0.
- DONE:
  - out_valid = 1; out_data = data register, held stable until the handshake.
  - On out_ready: out_valid falls next cycle and state returns to IDLE.
  - in_ready = 0 in DONE; no same-cycle turnaround.
- Latency, accept edge to out_valid high:
  - 5 cycles normal (4 compute + 1 into DONE).
  - 1 cycle bypass.
- Throughput: one block per 6 cycles when out_ready = 1 (IDLE 1 + BUSY 4 + DONE 1).
- Input signals are ignored outside IDLE; in_data changes during BUSY do not affect the result.
- out_ready while out_valid = 0 has no effect.
- out_data reflects the partially transformed register during BUSY; it is only meaningful when out_valid = 1.
- Reset asserted mid-BUSY or in DONE aborts the block, returns to IDLE with all outputs at reset values, and nothing is emitted.

Optional Feature:
- Macro: INV_MIX_EN
- Defined:
  - Port inv exists; its value is captured with in_data.
  - inv = 1 selects InvMixColumns with coefficients 0e,0b,0d,09 (row 0 = 0e a0 ^ 0b a1 ^ 0d a2 ^ 09 a3, rotated per row), built from chained xtime.
  - Latency is unchanged.
  - Bypass overrides inv.
- Not defined:
  - inv port absent; forward transform only; no inverse logic synthesised.

Test Plan:
- FIPS-197 App. B round 1, bypass = 0:
  - in_data = d4bf5d30e0b452aeb84111f11e2798e5 -> out_data = 046681e5e0cb199a48f8d37a2806264c.
  - out_valid rises 5 cycles after the accept edge.
- Single-column known vectors in column 0 (columns 1..3 = 01010101):
  - db135345 -> 8e4da1bc.
  - f20a225c -> 9fdc589d.
  - c6c6c6c6 -> c6c6c6c6.
  - 01010101 columns unchanged.
- Bypass: in_bypass = 1, in_data = 00112233445566778899aabbccddeeff -> identical out_data, out_valid 1 cycle after accept.
- Backpressure and reset:
  - Hold out_ready = 0 for 10 cycles: out_valid and out_data stay stable; in_ready = 0 throughout; second in_valid ignored.
  - Then pulse out_ready: in_ready = 1 the next cycle.
  - Reset asserted on the 2nd BUSY cycle: out_valid = 0, in_ready = 1 immediately; a new block afterwards produces the correct result.
- INV_MIX_EN, inv = 1: in_data = 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5.
- Back-to-back blocks with out_ready tied 1: accepts spaced exactly 6 cycles apart; each result is correct.
